// File: rtl/inst_realign_pkg.sv
// Shared types and helpers for the fetch-side instruction realigner.
package inst_realign_pkg;

  typedef enum logic [1:0] {
    RA_EMPTY     = 2'd0,
    RA_ISSUE     = 2'd1,
    RA_STR_WAIT  = 2'd2,
    RA_STR_ISSUE = 2'd3
  } ra_state_e;

  localparam logic [1:0] LAST_HALF = 2'd3;

  // Any parcel with [1:0]==2'b11 is taken as a 32-bit instruction.
  function automatic logic is_32bit(input logic [15:0] half);
    return half[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/inst_realign_pick.sv
// Combinational halfword selector: current/next parcel of the held block,
// instruction length, and whether the current instruction ends the block.
module inst_realign_pick
  import inst_realign_pkg::*;
(
  input  logic [63:0] hold_data,
  input  logic [1:0]  ptr,
  output logic [15:0] cur_half,
  output logic [15:0] next_half,
  output logic        is_32,
  output logic        ends_block
);

  logic [1:0] ptr_inc;

  always_comb begin
    ptr_inc    = ptr + 2'd1;
    cur_half   = hold_data[{ptr, 4'd0} +: 16];
    next_half  = hold_data[{ptr_inc, 4'd0} +: 16];
    is_32      = is_32bit(cur_half);
    // A 32-bit parcel at ptr 3 straddles and does not end the block here.
    ends_block = is_32 ? (ptr == 2'd2) : (ptr == LAST_HALF);
  end

endmodule

// File: rtl/inst_realign.sv
// Realigns 8-byte fetch blocks into one 16- or 32-bit instruction per
// handshake, carrying the low half of a block-straddling instruction.
module inst_realign
  import inst_realign_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [63:0] fetch_pc,
  input  logic [63:0] fetch_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [63:0] inst_pc,
  output logic [31:0] inst_raw,
  output logic        inst_is_rvc
);

  ra_state_e   state_q, state_d;
  logic [63:0] hold_data_q, hold_data_d;
  logic [60:0] hold_base_q, hold_base_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] carry_half_q, carry_half_d;
  logic [63:0] carry_pc_q, carry_pc_d;

  logic [15:0] cur_half, next_half;
  logic        is_32, ends_block;
  logic        straddle, fetch_fire, inst_fire;

  inst_realign_pick u_pick (
    .hold_data  (hold_data_q),
    .ptr        (ptr_q),
    .cur_half   (cur_half),
    .next_half  (next_half),
    .is_32      (is_32),
    .ends_block (ends_block)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RA_EMPTY;
      hold_data_q  <= '0;
      hold_base_q  <= '0;
      ptr_q        <= '0;
      carry_half_q <= '0;
      carry_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      hold_base_q  <= hold_base_d;
      ptr_q        <= ptr_d;
      carry_half_q <= carry_half_d;
      carry_pc_q   <= carry_pc_d;
    end
  end

  always_comb begin
    straddle    = (state_q == RA_ISSUE) && is_32 && (ptr_q == LAST_HALF);
    inst_valid  = 1'b0;
    inst_pc     = '0;
    inst_raw    = '0;
    fetch_ready = 1'b0;
    case (state_q)
      RA_EMPTY, RA_STR_WAIT: fetch_ready = 1'b1;
      RA_ISSUE: begin
        if (!straddle) begin
          inst_valid  = 1'b1;
          inst_pc     = {hold_base_q, ptr_q, 1'b0};
          inst_raw    = is_32 ? {next_half, cur_half} : {16'h0000, cur_half};
          // Refill in the same cycle the last parcel is consumed.
          fetch_ready = inst_ready && ends_block;
        end
      end
      RA_STR_ISSUE: begin
        inst_valid = 1'b1;
        inst_pc    = carry_pc_q;
        inst_raw   = {hold_data_q[15:0], carry_half_q};
      end
      default: ;
    endcase
    if (flush || !rst_n) fetch_ready = 1'b0;
    if (flush) begin
      inst_valid = 1'b0;
      inst_pc    = '0;
      inst_raw   = '0;
    end
    inst_is_rvc = inst_valid && (inst_raw[1:0] != 2'b11);
    fetch_fire  = fetch_valid && fetch_ready;
    inst_fire   = inst_valid && inst_ready;
  end

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    hold_base_d  = hold_base_q;
    ptr_d        = ptr_q;
    carry_half_d = carry_half_q;
    carry_pc_d   = carry_pc_q;
    if (flush) begin
      state_d      = RA_EMPTY;
      carry_half_d = '0;
      carry_pc_d   = '0;
    end else begin
      case (state_q)
        RA_EMPTY: begin
          if (fetch_fire) begin
            hold_data_d = fetch_data;
            hold_base_d = fetch_pc[63:3];
            ptr_d       = fetch_pc[2:1];
            state_d     = RA_ISSUE;
          end
        end
        RA_ISSUE: begin
          if (straddle) begin
            carry_half_d = cur_half;
            carry_pc_d   = {hold_base_q, 3'b110};
            state_d      = RA_STR_WAIT;
          end else if (inst_fire) begin
            if (ends_block) begin
              if (fetch_fire) begin
                hold_data_d = fetch_data;
                hold_base_d = fetch_pc[63:3];
                ptr_d       = fetch_pc[2:1];
              end else begin
                state_d = RA_EMPTY;
              end
            end else begin
              ptr_d = ptr_q + (is_32 ? 2'd2 : 2'd1);
            end
          end
        end
        RA_STR_WAIT: begin
          if (fetch_fire) begin
            hold_data_d = fetch_data;
            hold_base_d = fetch_pc[63:3];
            ptr_d       = fetch_pc[2:1];
            if (fetch_pc == carry_pc_q + 64'd2) begin
              state_d = RA_STR_ISSUE;
            end else begin
              // Non-sequential block: the carried half is meaningless now.
              state_d      = RA_ISSUE;
              carry_half_d = '0;
            end
          end
        end
        RA_STR_ISSUE: begin
          if (inst_fire) begin
            ptr_d   = 2'd1;
            state_d = RA_ISSUE;
          end
        end
        default: state_d = RA_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_realign.sv
// Directed bench for inst_realign: each scenario is a table of per-cycle
// inputs and hand-computed outputs, checked mid-cycle.
module tb_inst_realign;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [63:0] fetch_pc;
  logic [63:0] fetch_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [63:0] inst_pc;
  logic [31:0] inst_raw;
  logic        inst_is_rvc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rn;
    logic        fl;
    logic        fv;
    logic [63:0] fpc;
    logic [63:0] fd;
    logic        ir;
    logic        ev;
    logic [63:0] epc;
    logic [31:0] eraw;
    logic        ervc;
    logic        efr;
    logic        ck;
  } vec_t;

  inst_realign dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_pc    (fetch_pc),
    .fetch_data  (fetch_data),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_pc     (inst_pc),
    .inst_raw    (inst_raw),
    .inst_is_rvc (inst_is_rvc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  function automatic vec_t mk(input logic rn, input logic fl, input logic fv,
                              input logic [63:0] fpc, input logic [63:0] fd,
                              input logic ir, input logic ev, input logic [63:0] epc,
                              input logic [31:0] eraw, input logic ervc,
                              input logic efr, input logic ck);
    vec_t v;
    v.rn = rn; v.fl = fl; v.fv = fv; v.fpc = fpc; v.fd = fd; v.ir = ir;
    v.ev = ev; v.epc = epc; v.eraw = eraw; v.ervc = ervc; v.efr = efr; v.ck = ck;
    return v;
  endfunction

  task automatic test_reset();
    vec_t v[$];
    rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
    fetch_data = '0; inst_ready = 1'b0;
    @(posedge clk); #1;
    v.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,1));
    v.push_back(mk(1,0,0,0,0,0, 0,0,0,0,1,1));
    for (int i = 0; i < v.size(); i++) begin
      rst_n = v[i].rn; flush = v[i].fl; fetch_valid = v[i].fv;
      fetch_pc = v[i].fpc; fetch_data = v[i].fd; inst_ready = v[i].ir;
      #3;
      checks++; if (inst_valid !== v[i].ev) begin errors++; $display("FAIL reset[%0d] inst_valid got %b want %b", i, inst_valid, v[i].ev); end
      checks++; if (fetch_ready !== v[i].efr) begin errors++; $display("FAIL reset[%0d] fetch_ready got %b want %b", i, fetch_ready, v[i].efr); end
      if (v[i].ck) begin
        checks++; if (inst_pc !== v[i].epc) begin errors++; $display("FAIL reset[%0d] inst_pc got %h want %h", i, inst_pc, v[i].epc); end
        checks++; if (inst_raw !== v[i].eraw) begin errors++; $display("FAIL reset[%0d] inst_raw got %h want %h", i, inst_raw, v[i].eraw); end
        checks++; if (inst_is_rvc !== v[i].ervc) begin errors++; $display("FAIL reset[%0d] inst_is_rvc got %b want %b", i, inst_is_rvc, v[i].ervc); end
      end
      $display("reset[%0d]: rst_n=%b valid=%b fetch_ready=%b", i, rst_n, inst_valid, fetch_ready);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    vec_t v[$];
    logic [63:0] d = 64'h0000_0013_4501_4501;
    v.push_back(mk(1,0,1,B,d,1, 0,0,0,0,1,0));
    v.push_back(mk(1,0,0,0,0,1, 1,B,32'h0000_4501,1,0,1));
    v.push_back(mk(1,0,0,0,0,1, 1,B+2,32'h0000_4501,1,0,1));
    v.push_back(mk(1,0,0,0,0,1, 1,B+4,32'h0000_0013,0,1,1));
    v.push_back(mk(1,0,0,0,0,1, 0,0,0,0,1,0));
    for (int i = 0; i < v.size(); i++) begin
      rst_n = v[i].rn; flush = v[i].fl; fetch_valid = v[i].fv;
      fetch_pc = v[i].fpc; fetch_data = v[i].fd; inst_ready = v[i].ir;
      #3;
      checks++; if (inst_valid !== v[i].ev) begin errors++; $display("FAIL basic[%0d] inst_valid got %b want %b", i, inst_valid, v[i].ev); end
      checks++; if (fetch_ready !== v[i].efr) begin errors++; $display("FAIL basic[%0d] fetch_ready got %b want %b", i, fetch_ready, v[i].efr); end
      if (v[i].ck) begin
        checks++; if (inst_pc !== v[i].epc) begin errors++; $display("FAIL basic[%0d] inst_pc got %h want %h", i, inst_pc, v[i].epc); end
        checks++; if (inst_raw !== v[i].eraw) begin errors++; $display("FAIL basic[%0d] inst_raw got %h want %h", i, inst_raw, v[i].eraw); end
        checks++; if (inst_is_rvc !== v[i].ervc) begin errors++; $display("FAIL basic[%0d] inst_is_rvc got %b want %b", i, inst_is_rvc, v[i].ervc); end
      end
      $display("basic[%0d]: valid=%b pc=%h raw=%h rvc=%b fetch_ready=%b", i, inst_valid, inst_pc, inst_raw, inst_is_rvc, fetch_ready);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_straddle();
    vec_t v[$];
    logic [63:0] d1 = 64'h0513_4509_4505_4501;
    logic [63:0] d2 = 64'h4519_4515_4511_0000;
    v.push_back(mk(1,0,1,B,d1,1, 0,0,0,0,1,0));
    v.push_back(mk(1,0,0,0,0,1, 1,B,32'h0000_4501,1,0,1));
    v.push_back(mk(1,0,0,0,0,1, 1,B+2,32'h0000_4505,1,0,1));
    v.push_back(mk(1,0,0,0,0,1, 1,B+4,32'h0000_4509,1,0,1));
    v.push_back(mk(1,0,1,B+8,d2,1, 0,0,0,0,0,0));
    v.push_back(mk(1,0,1,B+8,d2,1, 0,0,0,0,1,0));
    v.push_back(mk(1,0,0,0,0,0, 1,B+6,32'h0000_0513,0,0,1));
    v.push_back(mk(1,0,0,0,0,1, 1,B+6,32'h0000_0513,0,0,1));
    v.push_back(mk(1,0,0,0,0,1, 1,B+10,32'h0000_4511,1,0,1));
    v.push_back(mk(1,0,0,0,0,1, 1,B+12,32'h0000_4515,1,0,1));
    v.push_back(mk(1,0,0,0,0,1, 1,B+14,32'h0000_4519,1,1,1));
    v.push_back(mk(1,0,0,0,0,1, 0,0,0,0,1,0));
    for (int i = 0; i < v.size(); i++) begin
      rst_n = v[i].rn; flush = v[i].fl; fetch_valid = v[i].fv;
      fetch_pc = v[i].fpc; fetch_data = v[i].fd; inst_ready = v[i].ir;
      #3;
      checks++; if (inst_valid !== v[i].ev) begin errors++; $display("FAIL straddle[%0d] inst_valid got %b want %b", i, inst_valid, v[i].ev); end
      checks++; if (fetch_ready !== v[i].efr) begin errors++; $display("FAIL straddle[%0d] fetch_ready got %b want %b", i, fetch_ready, v[i].efr); end
      if (v[i].ck) begin
        checks++; if (inst_pc !== v[i].epc) begin errors++; $display("FAIL straddle[%0d] inst_pc got %h want %h", i, inst_pc, v[i].epc); end
        checks++; if (inst_raw !== v[i].eraw) begin errors++; $display("FAIL straddle[%0d] inst_raw got %h want %h", i, inst_raw, v[i].eraw); end
        checks++; if (inst_is_rvc !== v[i].ervc) begin errors++; $display("FAIL straddle[%0d] inst_is_rvc got %b want %b", i, inst_is_rvc, v[i].ervc); end
      end
      $display("straddle[%0d]: valid=%b pc=%h raw=%h rvc=%b fetch_ready=%b", i, inst_valid, inst_pc, inst_raw, inst_is_rvc, fetch_ready);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump_back_to_back();
    vec_t v[$];
    logic [63:0] j  = 64'h0000_0000_8000_0106;
    logic [63:0] n  = 64'h0000_0000_8000_0108;
    logic [63:0] d1 = 64'h4501_ffff_ffff_ffff;
    logic [63:0] d2 = 64'h0000_0013_4509_4505;
    v.push_back(mk(1,0,1,j,d1,1, 0,0,0,0,1,0));
    v.push_back(mk(1,0,1,n,d2,1, 1,j,32'h0000_4501,1,1,1));
    v.push_back(mk(1,0,0,0,0,1, 1,n,32'h0000_4505,1,0,1));
    v.push_back(mk(1,0,0,0,0,1, 1,n+2,32'h0000_4509,1,0,1));
    v.push_back(mk(1,0,0,0,0,1, 1,n+4,32'h0000_0013,0,1,1));
    v.push_back(mk(1,0,0,0,0,1, 0,0,0,0,1,0));
    for (int i = 0; i < v.size(); i++) begin
      rst_n = v[i].rn; flush = v[i].fl; fetch_valid = v[i].fv;
      fetch_pc = v[i].fpc; fetch_data = v[i].fd; inst_ready = v[i].ir;
      #3;
      checks++; if (inst_valid !== v[i].ev) begin errors++; $display("FAIL jump[%0d] inst_valid got %b want %b", i, inst_valid, v[i].ev); end
      checks++; if (fetch_ready !== v[i].efr) begin errors++; $display("FAIL jump[%0d] fetch_ready got %b want %b", i, fetch_ready, v[i].efr); end
      if (v[i].ck) begin
        checks++; if (inst_pc !== v[i].epc) begin errors++; $display("FAIL jump[%0d] inst_pc got %h want %h", i, inst_pc, v[i].epc); end
        checks++; if (inst_raw !== v[i].eraw) begin errors++; $display("FAIL jump[%0d] inst_raw got %h want %h", i, inst_raw, v[i].eraw); end
        checks++; if (inst_is_rvc !== v[i].ervc) begin errors++; $display("FAIL jump[%0d] inst_is_rvc got %b want %b", i, inst_is_rvc, v[i].ervc); end
      end
      $display("jump[%0d]: valid=%b pc=%h raw=%h rvc=%b fetch_ready=%b", i, inst_valid, inst_pc, inst_raw, inst_is_rvc, fetch_ready);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    vec_t v[$];
    logic [63:0] p = 64'h0000_0000_8000_0200;
    logic [63:0] d = 64'h0000_0013_4509_4505;
    v.push_back(mk(1,0,1,p,d,1, 0,0,0,0,1,0));
    v.push_back(mk(1,0,0,0,0,1, 1,p,32'h0000_4505,1,0,1));
    for (int k = 0; k < 5; k++) v.push_back(mk(1,0,0,0,0,0, 1,p+2,32'h0000_4509,1,0,1));
    v.push_back(mk(1,0,0,0,0,1, 1,p+2,32'h0000_4509,1,0,1));
    v.push_back(mk(1,0,0,0,0,0, 1,p+4,32'h0000_0013,0,0,1));
    v.push_back(mk(1,0,0,0,0,1, 1,p+4,32'h0000_0013,0,1,1));
    v.push_back(mk(1,0,0,0,0,1, 0,0,0,0,1,0));
    for (int i = 0; i < v.size(); i++) begin
      rst_n = v[i].rn; flush = v[i].fl; fetch_valid = v[i].fv;
      fetch_pc = v[i].fpc; fetch_data = v[i].fd; inst_ready = v[i].ir;
      #3;
      checks++; if (inst_valid !== v[i].ev) begin errors++; $display("FAIL stall[%0d] inst_valid got %b want %b", i, inst_valid, v[i].ev); end
      checks++; if (fetch_ready !== v[i].efr) begin errors++; $display("FAIL stall[%0d] fetch_ready got %b want %b", i, fetch_ready, v[i].efr); end
      if (v[i].ck) begin
        checks++; if (inst_pc !== v[i].epc) begin errors++; $display("FAIL stall[%0d] inst_pc got %h want %h", i, inst_pc, v[i].epc); end
        checks++; if (inst_raw !== v[i].eraw) begin errors++; $display("FAIL stall[%0d] inst_raw got %h want %h", i, inst_raw, v[i].eraw); end
        checks++; if (inst_is_rvc !== v[i].ervc) begin errors++; $display("FAIL stall[%0d] inst_is_rvc got %b want %b", i, inst_is_rvc, v[i].ervc); end
      end
      $display("stall[%0d]: ready=%b valid=%b pc=%h raw=%h fetch_ready=%b", i, inst_ready, inst_valid, inst_pc, inst_raw, fetch_ready);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    vec_t v[$];
    logic [63:0] s  = 64'h0000_0000_8000_0406;
    logic [63:0] sn = 64'h0000_0000_8000_0408;
    logic [63:0] f  = 64'h0000_0000_8000_1000;
    logic [63:0] ds = 64'h0513_0000_0000_0000;
    logic [63:0] dn = 64'h4511_4511_4511_0000;
    logic [63:0] df = 64'h0000_0000_0000_0093;
    v.push_back(mk(1,0,1,s,ds,1, 0,0,0,0,1,0));
    v.push_back(mk(1,0,0,0,0,1, 0,0,0,0,0,0));
    v.push_back(mk(1,1,1,sn,dn,1, 0,0,0,0,0,0));
    v.push_back(mk(1,0,1,f,df,1, 0,0,0,0,1,0));
    v.push_back(mk(1,0,0,0,0,0, 1,f,32'h0000_0093,0,0,1));
    v.push_back(mk(1,1,0,0,0,1, 0,0,0,0,0,0));
    v.push_back(mk(1,0,1,s,ds,1, 0,0,0,0,1,0));
    v.push_back(mk(1,0,0,0,0,1, 0,0,0,0,0,0));
    v.push_back(mk(1,0,1,sn,dn,1, 0,0,0,0,1,0));
    v.push_back(mk(1,0,0,0,0,0, 1,s,32'h0000_0513,0,0,1));
    v.push_back(mk(1,1,0,0,0,1, 0,0,0,0,0,0));
    v.push_back(mk(1,0,1,f,df,1, 0,0,0,0,1,0));
    v.push_back(mk(1,0,0,0,0,1, 1,f,32'h0000_0093,0,0,1));
    v.push_back(mk(1,0,0,0,0,1, 1,f+4,32'h0000_0000,1,0,1));
    v.push_back(mk(1,0,0,0,0,1, 1,f+6,32'h0000_0000,1,1,1));
    v.push_back(mk(1,0,0,0,0,1, 0,0,0,0,1,0));
    for (int i = 0; i < v.size(); i++) begin
      rst_n = v[i].rn; flush = v[i].fl; fetch_valid = v[i].fv;
      fetch_pc = v[i].fpc; fetch_data = v[i].fd; inst_ready = v[i].ir;
      #3;
      checks++; if (inst_valid !== v[i].ev) begin errors++; $display("FAIL flush[%0d] inst_valid got %b want %b", i, inst_valid, v[i].ev); end
      checks++; if (fetch_ready !== v[i].efr) begin errors++; $display("FAIL flush[%0d] fetch_ready got %b want %b", i, fetch_ready, v[i].efr); end
      if (v[i].ck) begin
        checks++; if (inst_pc !== v[i].epc) begin errors++; $display("FAIL flush[%0d] inst_pc got %h want %h", i, inst_pc, v[i].epc); end
        checks++; if (inst_raw !== v[i].eraw) begin errors++; $display("FAIL flush[%0d] inst_raw got %h want %h", i, inst_raw, v[i].eraw); end
        checks++; if (inst_is_rvc !== v[i].ervc) begin errors++; $display("FAIL flush[%0d] inst_is_rvc got %b want %b", i, inst_is_rvc, v[i].ervc); end
      end
      $display("flush[%0d]: flush=%b valid=%b pc=%h raw=%h fetch_ready=%b", i, flush, inst_valid, inst_pc, inst_raw, fetch_ready);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    vec_t v[$];
    logic [63:0] d = 64'h0000_0013_4501_4501;
    v.push_back(mk(1,0,1,B,d,1, 0,0,0,0,1,0));
    v.push_back(mk(1,0,0,0,0,0, 1,B,32'h0000_4501,1,0,1));
    v.push_back(mk(0,0,1,B,d,1, 1,B,32'h0000_4501,1,0,1));
    v.push_back(mk(1,0,0,0,0,1, 0,0,0,0,1,1));
    v.push_back(mk(1,0,1,B,d,1, 0,0,0,0,1,0));
    v.push_back(mk(1,0,0,0,0,1, 1,B,32'h0000_4501,1,0,1));
    for (int i = 0; i < v.size(); i++) begin
      rst_n = v[i].rn; flush = v[i].fl; fetch_valid = v[i].fv;
      fetch_pc = v[i].fpc; fetch_data = v[i].fd; inst_ready = v[i].ir;
      #3;
      checks++; if (inst_valid !== v[i].ev) begin errors++; $display("FAIL rstmid[%0d] inst_valid got %b want %b", i, inst_valid, v[i].ev); end
      checks++; if (fetch_ready !== v[i].efr) begin errors++; $display("FAIL rstmid[%0d] fetch_ready got %b want %b", i, fetch_ready, v[i].efr); end
      if (v[i].ck) begin
        checks++; if (inst_pc !== v[i].epc) begin errors++; $display("FAIL rstmid[%0d] inst_pc got %h want %h", i, inst_pc, v[i].epc); end
        checks++; if (inst_raw !== v[i].eraw) begin errors++; $display("FAIL rstmid[%0d] inst_raw got %h want %h", i, inst_raw, v[i].eraw); end
        checks++; if (inst_is_rvc !== v[i].ervc) begin errors++; $display("FAIL rstmid[%0d] inst_is_rvc got %b want %b", i, inst_is_rvc, v[i].ervc); end
      end
      $display("rstmid[%0d]: rst_n=%b valid=%b pc=%h raw=%h fetch_ready=%b", i, rst_n, inst_valid, inst_pc, inst_raw, fetch_ready);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_straddle();
    test_jump_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
